// File: rtl/gnss_pkg.sv
// Shared GNSS types and constants, used by the epoch timer and the AHB GNSS satellite.
// Ports: none (package).
// Contents: epoch_t, GNSS_TICKS_PER_MS (16.368 MHz / 1 kHz), snapshot handshake state encoding.
package gnss_pkg;

  typedef logic [31:0] epoch_t;

  localparam int GNSS_TICKS_PER_MS = 16368;

  typedef enum logic {
    SNAP_EMPTY = 1'b0,
    SNAP_FULL  = 1'b1
  } snap_state_t;

endpackage

// File: rtl/gnss_epoch_timer_ms_prescaler.sv
// Generic modulo counter: counts 0..LAST while enabled, wraps to 0, flags the terminal count.
// Ports: clk, rst (sync, active-high), i_en (advance), i_clr (force to 0, beats i_en),
//        o_cnt (current count), o_tc (combinational: this cycle's advance wraps the counter).
module ms_prescaler #(
  parameter int          W    = 16,
  parameter int unsigned LAST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST_W = W'(LAST);

  logic [W-1:0] r_cnt;
  logic         w_at_last;

  assign w_at_last = (r_cnt == LAST_W);

  // A clear in the same cycle suppresses the wrap indication so callers
  // never see a terminal count that did not actually happen.
  assign o_tc  = i_en & ~i_clr & w_at_last;
  assign o_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/gnss_epoch_timer.sv
// Millisecond epoch timebase: divides clk into ms ticks, keeps a 32-bit epoch, snapshots
// epoch+phase on request (held until acked), and raises a decimated level interrupt.
// Ports: clk/rst(sync high), en, load/load_val, snapshot/snap_ack, irq_clr -> epoch, ms_tick,
//        snap_epoch/snap_tick/snap_valid/overrun, irq (drives interrupt_in_sync[17] upstream).
module gnss_epoch_timer
  import gnss_pkg::*;
#(
  parameter int TICKS_PER_MS = GNSS_TICKS_PER_MS,
  parameter int IRQ_DIV      = 1,
  parameter int TICK_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [31:0]       load_val,
  input  logic              snapshot,
  input  logic              snap_ack,
  input  logic              irq_clr,
  output logic [31:0]       epoch,
  output logic              ms_tick,
  output logic [31:0]       snap_epoch,
  output logic [TICK_W-1:0] snap_tick,
  output logic              snap_valid,
  output logic              overrun,
  output logic              irq
);

  localparam int IRQ_W = (IRQ_DIV > 1) ? $clog2(IRQ_DIV) : 1;

  logic [TICK_W-1:0] w_tick;
  logic              w_tick_tc;
  logic [IRQ_W-1:0]  w_irq_cnt_unused;
  logic              w_irq_tc;

  epoch_t            r_epoch;
  logic              r_ms_tick;
  epoch_t            r_snap_epoch;
  logic [TICK_W-1:0] r_snap_tick;
  logic              r_overrun;
  logic              r_irq;

  snap_state_t       r_state;
  snap_state_t       w_state_nxt;
  logic              w_capture;
  logic              w_ovr_set;

  // Sub-ms phase counter; load restarts the ms so its wrap is masked that cycle.
  ms_prescaler #(
    .W    (TICK_W),
    .LAST (TICKS_PER_MS - 1)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .i_en  (en),
    .i_clr (load),
    .o_cnt (w_tick),
    .o_tc  (w_tick_tc)
  );

  // Interrupt decimator counts ms_tick pulses; load realigns it with the new epoch.
  ms_prescaler #(
    .W    (IRQ_W),
    .LAST (IRQ_DIV - 1)
  ) u_irq_div (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_ms_tick),
    .i_clr (load),
    .o_cnt (w_irq_cnt_unused),
    .o_tc  (w_irq_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_epoch   <= '0;
      r_ms_tick <= 1'b0;
    end else begin
      r_ms_tick <= w_tick_tc;
      if (load) begin
        r_epoch <= load_val;
      end else if (w_tick_tc) begin
        r_epoch <= r_epoch + 32'd1;
      end
    end
  end

  // Snapshot handshake: next-state and capture/overrun strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      SNAP_EMPTY: begin
        if (snapshot) begin
          w_capture   = 1'b1;
          w_state_nxt = SNAP_FULL;
        end
      end
      SNAP_FULL: begin
        if (snapshot && snap_ack) begin
          w_capture = 1'b1;
        end else if (snapshot) begin
          w_ovr_set = 1'b1;
        end else if (snap_ack) begin
          w_state_nxt = SNAP_EMPTY;
        end
      end
      default: w_state_nxt = SNAP_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SNAP_EMPTY;
      r_snap_epoch <= '0;
      r_snap_tick  <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Registered values of this cycle: pre-increment and pre-load.
      if (w_capture) begin
        r_snap_epoch <= r_epoch;
        r_snap_tick  <= w_tick;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (snap_ack) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Set wins over a simultaneous clear so an epoch is never silently lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else if (w_irq_tc) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign epoch      = r_epoch;
  assign ms_tick    = r_ms_tick;
  assign snap_epoch = r_snap_epoch;
  assign snap_tick  = r_snap_tick;
  assign snap_valid = (r_state == SNAP_FULL);
  assign overrun    = r_overrun;
  assign irq        = r_irq;

endmodule

// File: tb/tb_gnss_epoch_timer.sv
module tb_gnss_epoch_timer;

  logic        clk = 1'b0;
  logic        rst, en, load, snapshot, snap_ack, irq_clr;
  logic [31:0] load_val;
  logic [31:0] epoch, snap_epoch;
  logic [15:0] snap_tick;
  logic        ms_tick, snap_valid, overrun, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gnss_epoch_timer #(
    .TICKS_PER_MS (4),
    .IRQ_DIV      (2),
    .TICK_W       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .snapshot   (snapshot),
    .snap_ack   (snap_ack),
    .irq_clr    (irq_clr),
    .epoch      (epoch),
    .ms_tick    (ms_tick),
    .snap_epoch (snap_epoch),
    .snap_tick  (snap_tick),
    .snap_valid (snap_valid),
    .overrun    (overrun),
    .irq        (irq)
  );

  typedef struct {
    logic        rst, en, ld;
    logic [31:0] ldv;
    logic        snp, ack, clr;
    logic [31:0] e;
    logic        mt, sv;
    logic [31:0] se;
    logic [15:0] st;
    logic        ov, irq;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic r, logic n, logic l, logic [31:0] lv, logic s, logic a,
                              logic c, logic [31:0] e, logic mt, logic sv, logic [31:0] se,
                              logic [15:0] st, logic ov, logic iq);
    vec_t v;
    v.rst = r; v.en = n; v.ld = l; v.ldv = lv; v.snp = s; v.ack = a; v.clr = c;
    v.e = e; v.mt = mt; v.sv = sv; v.se = se; v.st = st; v.ov = ov; v.irq = iq;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cyc;

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
    snapshot = 1'b0; snap_ack = 1'b0; irq_clr = 1'b0;

    //   rst en ld ldv           snp ack clr  epoch         mt sv se            st ov irq
    add(1, 0, 0, 32'h0,        0, 0, 0,  32'h0,        0, 0, 32'h0,    0, 0, 0); // r0 reset
    add(1, 1, 1, 32'h55,       1, 0, 0,  32'h0,        0, 0, 32'h0,    0, 0, 0); // r1 reset priority
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h0,        0, 0, 32'h0,    0, 0, 0); // r2
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h0,        0, 0, 32'h0,    0, 0, 0);
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h0,        0, 0, 32'h0,    0, 0, 0);
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h1,        1, 0, 32'h0,    0, 0, 0); // r5 first tick
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h1,        0, 0, 32'h0,    0, 0, 0);
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h1,        0, 0, 32'h0,    0, 0, 0);
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h1,        0, 0, 32'h0,    0, 0, 0);
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h2,        1, 0, 32'h0,    0, 0, 0); // r9 second tick
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h2,        0, 0, 32'h0,    0, 0, 1); // r10 irq set
    add(0, 1, 0, 32'h0,        0, 0, 1,  32'h2,        0, 0, 32'h0,    0, 0, 0); // r11 irq_clr alone
    add(0, 1, 1, 32'h5,        0, 0, 0,  32'h5,        0, 0, 32'h0,    0, 0, 0); // r12 load 5
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h5,        0, 0, 32'h0,    0, 0, 0);
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h5,        0, 0, 32'h0,    0, 0, 0);
    add(0, 1, 0, 32'h0,        1, 0, 0,  32'h5,        0, 1, 32'h5,    2, 0, 0); // r15 snapshot
    add(0, 1, 0, 32'h0,        0, 1, 0,  32'h6,        1, 0, 32'h5,    2, 0, 0); // r16 ack
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h6,        0, 0, 32'h5,    2, 0, 0);
    add(0, 1, 0, 32'h0,        1, 0, 0,  32'h6,        0, 1, 32'h6,    1, 0, 0); // r18 capture
    add(0, 1, 0, 32'h0,        1, 0, 0,  32'h6,        0, 1, 32'h6,    1, 1, 0); // r19 overrun
    add(0, 1, 0, 32'h0,        1, 1, 0,  32'h7,        1, 1, 32'h6,    3, 0, 0); // r20 snap+ack
    add(0, 1, 0, 32'h0,        0, 0, 1,  32'h7,        0, 1, 32'h6,    3, 0, 1); // r21 set beats clr
    add(0, 1, 0, 32'h0,        0, 0, 1,  32'h7,        0, 1, 32'h6,    3, 0, 0); // r22 clr
    add(0, 1, 0, 32'h0,        0, 1, 0,  32'h7,        0, 0, 32'h6,    3, 0, 0); // r23 ack
    add(0, 1, 0, 32'h0,        0, 1, 0,  32'h8,        1, 0, 32'h6,    3, 0, 0); // r24 ack on empty
    add(0, 1, 1, 32'hFFFFFFFF, 0, 0, 0,  32'hFFFFFFFF, 0, 0, 32'h6,    3, 0, 0); // r25 load max
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'hFFFFFFFF, 0, 0, 32'h6,    3, 0, 0);
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'hFFFFFFFF, 0, 0, 32'h6,    3, 0, 0);
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'hFFFFFFFF, 0, 0, 32'h6,    3, 0, 0);
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h0,        1, 0, 32'h6,    3, 0, 0); // r29 wrap
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h0,        0, 0, 32'h6,    3, 0, 0);
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h0,        0, 0, 32'h6,    3, 0, 0);
    add(0, 1, 0, 32'h0,        0, 0, 0,  32'h0,        0, 0, 32'h6,    3, 0, 0); // r32 tick=3
    add(0, 1, 1, 32'h1234,     0, 0, 0,  32'h1234,     0, 0, 32'h6,    3, 0, 0); // r33 load vs roll
    add(0, 1, 0, 32'h0,        1, 0, 0,  32'h1234,     0, 1, 32'h1234, 0, 0, 0); // r34 tick was 0
    add(0, 0, 0, 32'h0,        0, 1, 0,  32'h1234,     0, 0, 32'h1234, 0, 0, 0); // r35 en=0 start
    add(0, 0, 0, 32'h0,        0, 0, 0,  32'h1234,     0, 0, 32'h1234, 0, 0, 0);
    add(0, 0, 0, 32'h0,        0, 0, 0,  32'h1234,     0, 0, 32'h1234, 0, 0, 0);
    add(0, 0, 0, 32'h0,        1, 0, 0,  32'h1234,     0, 1, 32'h1234, 1, 0, 0); // r38 frozen capture
    add(0, 0, 0, 32'h0,        0, 1, 0,  32'h1234,     0, 0, 32'h1234, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 32'h0,      0, 0, 0,  32'h1234,     0, 0, 32'h1234, 1, 0, 0); // r40..r44
    add(0, 1, 0, 32'h0,        1, 0, 0,  32'h1234,     0, 1, 32'h1234, 1, 0, 0); // r45 capture
    add(1, 1, 0, 32'h0,        0, 0, 0,  32'h0,        0, 0, 32'h0,    0, 0, 0); // r46 rst mid-capture
    add(0, 0, 0, 32'h0,        0, 0, 0,  32'h0,        0, 0, 32'h0,    0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; en = vq[i].en; load = vq[i].ld; load_val = vq[i].ldv;
      snapshot = vq[i].snp; snap_ack = vq[i].ack; irq_clr = vq[i].clr;
      step();
      chk($sformatf("r%0d epoch", i),      epoch,      vq[i].e);
      chk($sformatf("r%0d ms_tick", i),    ms_tick,    vq[i].mt);
      chk($sformatf("r%0d snap_valid", i), snap_valid, vq[i].sv);
      chk($sformatf("r%0d snap_epoch", i), snap_epoch, vq[i].se);
      chk($sformatf("r%0d snap_tick", i),  snap_tick,  vq[i].st);
      chk($sformatf("r%0d overrun", i),    overrun,    vq[i].ov);
      chk($sformatf("r%0d irq", i),        irq,        vq[i].irq);
    end

    // Tick spacing and irq timing from a fresh reset, with bounded waits.
    rst = 1'b0; en = 1'b1; load = 1'b0; snapshot = 1'b0; snap_ack = 1'b0; irq_clr = 1'b0;
    cyc = 0;
    do begin step(); cyc++; end while (!ms_tick && cyc < 20);
    chk("first ms_tick latency", cyc, 4);
    cyc = 0;
    do begin step(); cyc++; end while (!ms_tick && cyc < 20);
    chk("ms_tick spacing", cyc, 4);
    chk("epoch after two ticks", epoch, 2);
    chk("irq before decimated set", irq, 0);
    step();
    chk("irq after second tick", irq, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
